dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage
//  (EX/MEM ALU result as address, forwarded rs2 as store data) and a line-wide main memory.
//  Hits complete in the MEM cycle; misses hold the pipeline via cpu_stall_o while an FSM
//  writes back a dirty victim and refills the line over a req/ack memory handshake.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  LINES       16  number of cache lines (power of 2)
//  LINE_WORDS  4   32-bit words per line (power of 2); memory data width = 32*LINE_WORDS
// PORTS
//  clk_i        in   1            clock, all state updates on rising edge
//  rst_i        in   1            synchronous, active-high reset
//  cpu_req_i    in   1            MEM-stage access valid (MemRead | MemWrite)
//  cpu_we_i     in   1            1 = store word, 0 = load word
//  cpu_addr_i   in   ADDR_W       byte address; [1:0] ignored
//  cpu_wdata_i  in   32           store data
//  cpu_rdata_o  out  32           load data, valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
//  cpu_stall_o  out  1            1 = freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
//  mem_req_o    out  1            memory transaction request (registered)
//  mem_we_o     out  1            1 = line write-back, 0 = line fetch
//  mem_addr_o   out  ADDR_W       line-aligned address
//  mem_wdata_o  out  32*LINE_WORDS victim line data
//  mem_rdata_i  in   32*LINE_WORDS refill line data, sampled with mem_ack_i
//  mem_ack_i    in   1            one-cycle completion pulse; honoured only while mem_req_o=1
// BEHAVIOUR
//  Address split: offset=[log2(LINE_WORDS)+1:2], index=next log2(LINES) bits, tag=rest.
//  Reset: all valid/dirty bits cleared, state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0,
//   mem_wdata_o=0, cpu_stall_o=0, cpu_rdata_o=0. Data/tag arrays not reset.
//  FSM states: IDLE, WRITEBACK, ALLOCATE, RESOLVE.
//  IDLE: hit = cpu_req_i & valid[index] & tag match. Hit: stall=0, load data combinational
//   same cycle; store writes word and sets dirty at the clock edge. Miss: stall=1 combinational;
//   -> WRITEBACK if victim valid & dirty, else -> ALLOCATE. No request: stall=0, stay.
//  WRITEBACK: mem_req_o=1, mem_we_o=1, addr={victim tag,index,0}, wdata=victim line.
//   On mem_ack_i: clear dirty, -> ALLOCATE.
//  ALLOCATE: mem_req_o=1, mem_we_o=0, addr={cpu tag,index,0}. On mem_ack_i: write
//   mem_rdata_i to line, tag updated, valid=1, dirty=0, -> RESOLVE.
//  RESOLVE: stall=0; access performed as a guaranteed hit (load returns word, store merges
//   and sets dirty); -> IDLE.
//  stall=1 in WRITEBACK and ALLOCATE. Clean-miss stall = 2 + ack latency cycles
//   (miss cycle, ALLOCATE cycles up to ack); dirty miss adds the WRITEBACK cycles.
//  CPU holds cpu_req_i/we/addr/wdata stable while stall=1; a change mid-miss is a protocol
//   violation (assertion), behaviour undefined.
//  mem_req_o held high until ack; mem_ack_i with mem_req_o=0 ignored. Ack in the first
//   req cycle is legal (minimum transaction = 1 cycle).
//  Reset mid-miss: FSM -> IDLE, mem_req_o drops next edge, transaction abandoned, line
//   contents lost (dirty data discarded).
//  Word writes only; no byte enables, no uncached region.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs stat_hit_o[31:0], stat_miss_o[31:0], stat_wb_o[31:0];
//   hit counts IDLE hits, miss counts IDLE->miss transitions, wb counts WRITEBACK acks;
//   all cleared by rst_i, wrap at 2^32. Undefined: ports and counters absent, core
//   behaviour identical.
// STRUCTURE
//  dcache_pkg: state enum (IDLE/WRITEBACK/ALLOCATE/RESOLVE), derived widths
//   (OFFSET_W, INDEX_W, TAG_W, LINE_W), address-field extraction functions.
//  Sub-module dcache_array: tag/valid/dirty/data storage, 1 async read port, 1 write port
//   (line write or word merge); dcache_ctrl holds FSM and hit logic.
// TESTING
//  Cold load 0x100 -> stall, ALLOCATE req addr 0x100, ack after 3 cycles with line
//   {D,C,B,A} -> RESOLVE returns A, then load 0x104 hits with B, stall=0.
//  Store 0xDEAD_BEEF to 0x108 (line resident) -> no stall, no mem_req; load 0x108 -> 0xDEADBEEF.
//  Dirty conflict: LINES=16 -> load 0x500 after dirty 0x100 -> WRITEBACK addr 0x100 with
//   modified line, then ALLOCATE 0x500; reload 0x100 refetches written data.
//  Ack in first req cycle -> clean miss stall exactly 2 cycles; spurious ack in IDLE ignored.
//  rst_i during ALLOCATE -> next cycle IDLE, mem_req_o=0, load 0x100 misses again.
//  DCACHE_STATS_EN: sequence of 3 hits, 2 misses (1 dirty) -> hit=3, miss=2, wb=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;
  localparam int ADDR_W_DEF     = 32;
  localparam int LINES_DEF      = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int OFFSET_W       = $clog2(LINE_WORDS_DEF);
  localparam int INDEX_W        = $clog2(LINES_DEF);
  localparam int TAG_W          = ADDR_W_DEF - INDEX_W - OFFSET_W - 2;
  localparam int LINE_W         = 32 * LINE_WORDS_DEF;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESOLVE} state_e;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W_DEF-1:0] a);
    return a[OFFSET_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W_DEF-1:0] a);
    return a[OFFSET_W+2 +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W_DEF-1:0] a);
    return a[ADDR_W_DEF-1 -: TAG_W];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one asynchronous read port, one write port
// (full-line refill or single-word merge) plus a dirty-clear strobe.
module dcache_array #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  localparam int IW = $clog2(LINES),
  localparam int OW = $clog2(LINE_WORDS),
  localparam int LW = 32 * LINE_WORDS
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] idx_i,
  input  logic [OW-1:0] off_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic          line_we_i,
  input  logic [LW-1:0] line_i,
  input  logic          word_we_i,
  input  logic [31:0]   word_i,
  input  logic          clr_dirty_i,
  output logic          valid_o,
  output logic          dirty_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [LW-1:0] line_o
);
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LW-1:0]    data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_we_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end
      if (word_we_i)   dirty_q[idx_i] <= 1'b1;
      if (clr_dirty_i) dirty_q[idx_i] <= 1'b0;
    end
  end

  // Payload storage is deliberately left unreset; valid bits gate its use.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= line_i;
    end else if (word_we_i) begin
      data_q[idx_i][{off_i, 5'd0} +: 32] <= word_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: hit logic and miss FSM.
// Optional DCACHE_STATS_EN adds hit/miss/write-back event counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  localparam int OW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(LINES),
  localparam int TW = ADDR_W - IW - OW - 2,
  localparam int LW = 32 * LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LW-1:0]     mem_wdata_o,
  input  logic [LW-1:0]     mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o,
  output logic [31:0]       stat_wb_o
`endif
);
  state_e state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]     mem_wdata_q, mem_wdata_d;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          arr_valid, arr_dirty, line_we, word_we, clr_dirty, hit, ack;
  logic [TW-1:0] arr_tag;
  logic [LW-1:0] arr_line;
  logic [31:0]   rd_word;
  logic          unused_addr_lsb;

  assign off = cpu_addr_i[OW+1:2];
  assign idx = cpu_addr_i[OW+2 +: IW];
  assign tag = cpu_addr_i[ADDR_W-1 -: TW];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  dcache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TW)) u_array (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .off_i      (off),
    .tag_i      (tag),
    .line_we_i  (line_we),
    .line_i     (mem_rdata_i),
    .word_we_i  (word_we),
    .word_i     (cpu_wdata_i),
    .clr_dirty_i(clr_dirty),
    .valid_o    (arr_valid),
    .dirty_o    (arr_dirty),
    .tag_o      (arr_tag),
    .line_o     (arr_line)
  );

  assign ack     = mem_ack_i & mem_req_q;
  assign hit     = cpu_req_i & arr_valid & (arr_tag == tag);
  assign rd_word = arr_line[{off, 5'd0} +: 32];

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    clr_dirty   = 1'b0;
    unique case (state_q)
      IDLE: if (cpu_req_i) begin
        if (hit) begin
          if (cpu_we_i) word_we = 1'b1;
          else          cpu_rdata_o = rd_word;
        end else begin
          cpu_stall_o = 1'b1;
          mem_req_d   = 1'b1;
          if (arr_valid && arr_dirty) begin
            state_d     = WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {arr_tag, idx, {(OW+2){1'b0}}};
            mem_wdata_d = arr_line;
          end else begin
            state_d    = ALLOCATE;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, idx, {(OW+2){1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        if (ack) begin
          clr_dirty  = 1'b1;
          state_d    = ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, idx, {(OW+2){1'b0}}};
        end
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        if (ack) begin
          line_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        // Line was just refilled, so this access is a hit by construction.
        if (cpu_req_i) begin
          if (cpu_we_i) word_we = 1'b1;
          else          cpu_rdata_o = rd_word;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      cpu_stall_o = 1'b0;
      cpu_rdata_o = '0;
      line_we     = 1'b0;
      word_we     = 1'b0;
      clr_dirty   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && hit)                   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && cpu_req_i && !hit)     miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITEBACK && ack)              wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end
  assign stat_hit_o  = hit_cnt_q;
  assign stat_miss_o = miss_cnt_q;
  assign stat_wb_o   = wb_cnt_q;
`endif

  // The CPU must hold its request steady for the whole miss.
  a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    cpu_stall_o |=> (cpu_req_i && $stable(cpu_we_i) && $stable(cpu_addr_i) && $stable(cpu_wdata_i)));
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then random traffic
// against a flat-memory reference plus a line-residency model.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0]       cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o, mem_req_o, mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i = '0;
  logic              mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]       stat_hit_o, stat_miss_o, stat_wb_o;
`endif

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int ack_lat = 0, req_cnt = 0;
  bit spur = 1'b0;
  logic [31:0] mem_w [int unsigned];
  logic [31:0] ref_w [int unsigned];
  logic              tx_we   [$];
  logic [31:0]       tx_addr [$];
  logic [LINE_W-1:0] tx_data [$];
  bit                mvalid [LINES_DEF];
  bit                mdirty [LINES_DEF];
  logic [TAG_W-1:0]  mtag   [LINES_DEF];
  int e_hit = 0, e_miss = 0, e_wb = 0;

  function automatic logic [31:0] init_word(input int unsigned k);
    return (k * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction
  function automatic logic [31:0] rd_mem(input int unsigned k);
    return mem_w.exists(k) ? mem_w[k] : init_word(k);
  endfunction
  function automatic logic [31:0] rd_ref(input int unsigned k);
    return ref_w.exists(k) ? ref_w[k] : init_word(k);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Main memory: acks ack_lat cycles after a request starts, spurious ack on demand.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (rst_i || !mem_req_o) req_cnt = 0;
    else if (req_cnt >= ack_lat) begin
      mem_ack_i = 1'b1;
      req_cnt = 0;
      tx_we.push_back(mem_we_o);
      tx_addr.push_back(mem_addr_o);
      tx_data.push_back(mem_wdata_o);
      for (int w = 0; w < LINE_WORDS_DEF; w++) begin
        if (mem_we_o) mem_w[(mem_addr_o >> 2) + w] = mem_wdata_o[w*32 +: 32];
        else          mem_rdata_i[w*32 +: 32] = rd_mem((mem_addr_o >> 2) + w);
      end
    end else req_cnt++;
    if (spur) mem_ack_i = 1'b1;
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic [31:0]        vaddr, laddr;
    logic [LINE_W-1:0]  vline;
    bit hit, wb;
    int stalls, exp_st, n_tx;
    idx   = addr_index(addr);
    tg    = addr_tag(addr);
    laddr = addr & ~32'hF;
    vaddr = {mtag[idx], idx, 4'b0};
    hit   = mvalid[idx] && mtag[idx] == tg;
    wb    = !hit && mvalid[idx] && mdirty[idx];
    exp_st = hit ? 0 : 2 + ack_lat + (wb ? ack_lat + 1 : 0);
    n_tx   = hit ? 0 : (wb ? 2 : 1);
    for (int w = 0; w < LINE_WORDS_DEF; w++) vline[w*32 +: 32] = rd_ref((vaddr >> 2) + w);
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    stalls = 0;
    #1;
    while (cpu_stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd = cpu_rdata_o;
    chk("stall_cycles", 128'(stalls), 128'(exp_st));
    if (!we) chk("load_data", 128'(cpu_rdata_o), 128'(rd_ref(addr >> 2)));
    chk("tx_count", 128'(tx_we.size()), 128'(n_tx));
    if (tx_we.size() == n_tx && n_tx > 0) begin
      if (wb) begin
        chk("wb_we", 128'(tx_we.pop_front()), 128'(1));
        chk("wb_addr", 128'(tx_addr.pop_front()), 128'(vaddr));
        chk("wb_data", tx_data.pop_front(), vline);
      end
      chk("alloc_we", 128'(tx_we.pop_front()), 128'(0));
      chk("alloc_addr", 128'(tx_addr.pop_front()), 128'(laddr));
    end
    tx_we.delete(); tx_addr.delete(); tx_data.delete();
    if (hit) e_hit++; else e_miss++;
    if (wb) e_wb++;
    mdirty[idx] = hit ? (mdirty[idx] | we) : we;
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (we) ref_w[addr >> 2] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    // Dirty lines are discarded: the architectural view falls back to memory.
    for (int i = 0; i < LINES_DEF; i++) begin
      if (mvalid[i] && mdirty[i])
        for (int w = 0; w < LINE_WORDS_DEF; w++)
          ref_w[({mtag[i], 4'(i), 4'b0} >> 2) + w] = rd_mem(({mtag[i], 4'(i), 4'b0} >> 2) + w);
      mvalid[i] = 1'b0; mdirty[i] = 1'b0;
    end
    tx_we.delete(); tx_addr.delete(); tx_data.delete();
    e_hit = 0; e_miss = 0; e_wb = 0;
    #1;
    chk("rst_stall", 128'(cpu_stall_o), 128'(0));
    chk("rst_mem_req", 128'(mem_req_o), 128'(0));
    chk("rst_mem_we", 128'(mem_we_o), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr_o), 128'(0));
    chk("rst_mem_wdata", mem_wdata_o, 128'(0));
    chk("rst_rdata", 128'(cpu_rdata_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] wa [4];
    wa[0] = 32'h0A0A_0A0A; wa[1] = 32'h0B0B_0B0B; wa[2] = 32'h0C0C_0C0C; wa[3] = 32'h0D0D_0D0D;
    for (int w = 0; w < 4; w++) begin
      mem_w[(32'h100 >> 2) + w] = wa[w];
      ref_w[(32'h100 >> 2) + w] = wa[w];
    end
    for (int i = 0; i < LINES_DEF; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end
    do_reset();

    ack_lat = 3;
    access(1'b0, 32'h100, '0, rd);
    chk("cold_load_A", 128'(rd), 128'(wa[0]));
    access(1'b0, 32'h104, '0, rd);
    chk("hit_load_B", 128'(rd), 128'(wa[1]));
    access(1'b1, 32'h108, 32'hDEAD_BEEF, rd);
    access(1'b0, 32'h108, '0, rd);
    chk("store_readback", 128'(rd), 128'(32'hDEAD_BEEF));

    ack_lat = 1;
    access(1'b0, 32'h500, '0, rd);
    access(1'b0, 32'h108, '0, rd);
    chk("refetch_written", 128'(rd), 128'(32'hDEAD_BEEF));

    ack_lat = 0;
    access(1'b0, 32'h200, '0, rd);

    @(negedge clk);
    cpu_req_i = 1'b0;
    #2 spur = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("spur_no_req", 128'(mem_req_o), 128'(0));
    chk("spur_no_stall", 128'(cpu_stall_o), 128'(0));
    spur = 1'b0;
    access(1'b0, 32'h200, '0, rd);

    access(1'b1, 32'h110, 32'h1234_ABCD, rd);
    ack_lat = 20;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    repeat (2) @(negedge clk);
    #1;
    chk("alloc_req", 128'({mem_req_o, mem_we_o, cpu_stall_o}), 128'(3'b101));
    chk("alloc_addr_mid", 128'(mem_addr_o), 128'(32'h300));
    do_reset();
    ack_lat = 1;
    access(1'b0, 32'h100, '0, rd);
    access(1'b0, 32'h110, '0, rd);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(1, 4) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      ack_lat = $urandom_range(0, 3);
      access(1'($urandom_range(0, 1)), a, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        cpu_req_i = 1'b0;
      end
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    cpu_req_i = 1'b0;
    @(negedge clk);
    chk("stat_hit", 128'(stat_hit_o), 128'(e_hit));
    chk("stat_miss", 128'(stat_miss_o), 128'(e_miss));
    chk("stat_wb", 128'(stat_wb_o), 128'(e_wb));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
